// File: rtl/gray_sobel.sv
// Streaming 3x3 Sobel edge detector with two internal line buffers and a 3-stage output pipeline.
// Optional macro SOBEL_THRESH_EN turns the saturated magnitude into a 0/255 binary output.
module gray_sobel #(
    parameter int         WIDTH  = 200,
    parameter int         HEIGHT = 200,
    parameter logic [7:0] THRESH = 8'd128
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic [7:0] gray,
    input  logic       gray_valid,
    input  logic       gray_hsync,
    input  logic       gray_vsync,
    output logic [7:0] edge_data,
    output logic       edge_valid,
    output logic       edge_hsync,
    output logic       edge_vsync
);

    localparam int AW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int RW = $clog2(HEIGHT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [AW-1:0] COL_LAST   = AW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(WIDTH);

    function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        logic [10:0] r;
        if (v[10]) begin
            r = 11'(-v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [7:0] sat8(input logic [11:0] m);
        return (m > 12'd255) ? 8'hFF : m[7:0];
    endfunction

    logic [1:0]    state_r;
    logic          vsync_prev_r;
    logic [AW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] fcnt_r;
    logic [AW-1:0] ocol_r;
    logic [RW-1:0] orow_r;
    logic [7:0]    lb0_r [0:WIDTH-1];
    logic [7:0]    lb1_r [0:WIDTH-1];
    logic [7:0]    win_r [0:2][0:2];

    logic                v0_r, b0_r, f0_r, l0_r;
    logic                v1_r, b1_r, f1_r, l1_r;
    logic                v2_r, b2_r, f2_r, l2_r;
    logic signed [10:0]  gx_r, gy_r;
    logic [11:0]         mag_r;
    logic                last_r;

    logic          vs_rise_s, vs_fall_s, kill_s;
    logic          accept_s, flush_step_s, step_s, emit_s;
    logic [7:0]    pix_s, top_s, mid_s;
    logic [AW-1:0] col_next_s;
    logic          border_s, first_s, last_s;
    logic signed [10:0] gx_s, gy_s;
    logic [11:0]   mag_s;
    logic [7:0]    out_val_s;
    logic          unused_s;

    // Frame control decode: vsync edges, abort, and which cycles advance the window.
    always_comb begin
        vs_rise_s = gray_vsync & ~vsync_prev_r;
        vs_fall_s = ~gray_vsync & vsync_prev_r;
        if (vs_rise_s && (state_r != ST_IDLE)) begin
            kill_s = 1'b1;
        end else if (vs_fall_s && ((state_r == ST_FILL) || (state_r == ST_RUN))) begin
            kill_s = 1'b1;
        end else begin
            kill_s = 1'b0;
        end
        accept_s     = gray_valid && ((state_r == ST_FILL) || (state_r == ST_RUN)) && !vs_rise_s && !kill_s;
        flush_step_s = (state_r == ST_FLUSH) && !vs_rise_s;
        step_s       = accept_s || flush_step_s;
        // Input index WIDTH+1 (row 1, col 1) is the first step that completes a window.
        emit_s = flush_step_s ||
                 (accept_s && ((state_r == ST_RUN) || ((row_r == RW'(1)) && (col_r == AW'(1)))));
        pix_s      = flush_step_s ? 8'd0 : gray;
        top_s      = lb1_r[col_r];
        mid_s      = lb0_r[col_r];
        col_next_s = (col_r == COL_LAST) ? {AW{1'b0}} : col_r + AW'(1);
        border_s   = (orow_r == {RW{1'b0}}) || (orow_r == ROW_LAST) ||
                     (ocol_r == {AW{1'b0}}) || (ocol_r == COL_LAST);
        first_s    = (orow_r == {RW{1'b0}}) && (ocol_r == {AW{1'b0}});
        last_s     = (orow_r == ROW_LAST) && (ocol_r == COL_LAST);
    end

    // State machine, raster counters and the 3x3 window shift register.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_r      <= ST_IDLE;
            vsync_prev_r <= 1'b0;
            col_r        <= {AW{1'b0}};
            row_r        <= {RW{1'b0}};
            fcnt_r       <= {CW{1'b0}};
            ocol_r       <= {AW{1'b0}};
            orow_r       <= {RW{1'b0}};
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_r[i][j] <= 8'd0;
                end
            end
        end else begin
            vsync_prev_r <= gray_vsync;
            if (vs_rise_s) begin
                state_r <= ST_FILL;
                col_r   <= {AW{1'b0}};
                row_r   <= {RW{1'b0}};
                fcnt_r  <= {CW{1'b0}};
                ocol_r  <= {AW{1'b0}};
                orow_r  <= {RW{1'b0}};
            end else if (kill_s) begin
                state_r <= ST_IDLE;
            end else if (step_s) begin
                for (int i = 0; i < 3; i++) begin
                    win_r[i][0] <= win_r[i][1];
                    win_r[i][1] <= win_r[i][2];
                end
                win_r[0][2] <= top_s;
                win_r[1][2] <= mid_s;
                win_r[2][2] <= pix_s;
                col_r <= col_next_s;
                if (accept_s && (col_r == COL_LAST)) begin
                    row_r <= row_r + RW'(1);
                end
                if (emit_s) begin
                    if (ocol_r == COL_LAST) begin
                        ocol_r <= {AW{1'b0}};
                        orow_r <= orow_r + RW'(1);
                    end else begin
                        ocol_r <= ocol_r + AW'(1);
                    end
                end
                case (state_r)
                    ST_FILL: begin
                        if ((row_r == RW'(1)) && (col_r == AW'(1))) begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
                            state_r <= ST_FLUSH;
                            fcnt_r  <= {CW{1'b0}};
                        end
                    end
                    ST_FLUSH: begin
                        if (fcnt_r == FLUSH_LAST) begin
                            state_r <= ST_IDLE;
                        end else begin
                            fcnt_r <= fcnt_r + CW'(1);
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    // Line buffers: read-before-write so the previous row cascades from buffer 0 into buffer 1.
    always_ff @(posedge clk) begin
        if (step_s) begin
            lb0_r[col_r] <= pix_s;
            lb1_r[col_r] <= mid_s;
        end
    end

    // Gradient and magnitude arithmetic on the current window and the registered gradients.
    always_comb begin
        gx_s  = $signed({1'b0, tap_sum(win_r[0][2], win_r[1][2], win_r[2][2])}) -
                $signed({1'b0, tap_sum(win_r[0][0], win_r[1][0], win_r[2][0])});
        gy_s  = $signed({1'b0, tap_sum(win_r[2][0], win_r[2][1], win_r[2][2])}) -
                $signed({1'b0, tap_sum(win_r[0][0], win_r[0][1], win_r[0][2])});
        mag_s = {1'b0, abs11(gx_r)} + {1'b0, abs11(gy_r)};
    end

`ifdef SOBEL_THRESH_EN
    assign out_val_s = (sat8(mag_r) >= THRESH) ? 8'hFF : 8'h00;
    assign unused_s  = gray_hsync;
`else
    assign out_val_s = sat8(mag_r);
    assign unused_s  = ^{gray_hsync, THRESH};
`endif

    // Output pipeline; an abort or restart drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst_p || kill_s) begin
            v0_r <= 1'b0; b0_r <= 1'b0; f0_r <= 1'b0; l0_r <= 1'b0;
            v1_r <= 1'b0; b1_r <= 1'b0; f1_r <= 1'b0; l1_r <= 1'b0;
            v2_r <= 1'b0; b2_r <= 1'b0; f2_r <= 1'b0; l2_r <= 1'b0;
            gx_r       <= 11'sd0;
            gy_r       <= 11'sd0;
            mag_r      <= 12'd0;
            last_r     <= 1'b0;
            edge_data  <= 8'd0;
            edge_valid <= 1'b0;
            edge_hsync <= 1'b0;
            edge_vsync <= 1'b0;
        end else begin
            v0_r <= emit_s;
            b0_r <= border_s;
            f0_r <= first_s;
            l0_r <= last_s;
            v1_r <= v0_r; b1_r <= b0_r; f1_r <= f0_r; l1_r <= l0_r;
            gx_r <= gx_s;
            gy_r <= gy_s;
            v2_r <= v1_r; b2_r <= b1_r; f2_r <= f1_r; l2_r <= l1_r;
            mag_r <= mag_s;
            edge_valid <= v2_r;
            edge_hsync <= v2_r;
            edge_data  <= (v2_r && !b2_r) ? out_val_s : 8'd0;
            last_r     <= v2_r && l2_r;
            if (v2_r && f2_r) begin
                edge_vsync <= 1'b1;
            end else if (edge_valid && last_r) begin
                edge_vsync <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_sobel.sv
// Directed bench for gray_sobel on a small 8x6 frame with closed-form expected edge maps.
module tb_gray_sobel;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    localparam int P_CONST   = 0;
    localparam int P_VSTEP   = 1;
    localparam int P_RAMP    = 2;
    localparam int P_HSTEP   = 3;
    localparam int P_IMPULSE = 4;
    localparam int P_DRAMP   = 5;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [7:0] gray;
    logic       gray_valid, gray_hsync, gray_vsync;
    logic [7:0] edge_data;
    logic       edge_valid, edge_hsync, edge_vsync;

    always #5 clk = ~clk;

    gray_sobel #(.WIDTH(W), .HEIGHT(H), .THRESH(8'd128)) dut (
        .clk(clk), .rst_p(rst_p), .gray(gray), .gray_valid(gray_valid),
        .gray_hsync(gray_hsync), .gray_vsync(gray_vsync), .edge_data(edge_data),
        .edge_valid(edge_valid), .edge_hsync(edge_hsync), .edge_vsync(edge_vsync)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got [0:2047];
    int out_cyc [0:2047];
    int n_tot = 0;
    int vs_tot = 0;
    int hs_bad = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        if (edge_valid) begin
            if (n_tot < 2048) begin
                got[n_tot] = edge_data;
                out_cyc[n_tot] = cyc;
            end
            n_tot++;
        end
        if (edge_vsync) vs_tot++;
        if (edge_hsync !== edge_valid) hs_bad++;
    end

    function automatic logic [7:0] pix_of(input int pat, input int r, input int c);
        case (pat)
            P_CONST:   return 8'h80;
            P_VSTEP:   return (c < W / 2) ? 8'h00 : 8'hFF;
            P_RAMP:    return 8'(c);
            P_HSTEP:   return (r < 3) ? 8'd0 : 8'd10;
            P_IMPULSE: return (r == 2 && c == 3) ? 8'd100 : 8'd0;
            P_DRAMP:   return 8'(20 * (7 - c));
            default:   return 8'd0;
        endcase
    endfunction

    // Hand-derived edge maps: step gives 4*255 saturated at cols 3/4, ramp +8, hstep Gy 40,
    // impulse 100 gives magnitude 200 on its 8 neighbours, descending ramp |Gx| = 160.
    function automatic logic [7:0] exp_of(input int pat, input int r, input int c);
        logic [7:0] v;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        case (pat)
            P_VSTEP:   v = (c == 3 || c == 4) ? 8'd255 : 8'd0;
            P_RAMP:    v = 8'd8;
            P_HSTEP:   v = (r == 2 || r == 3) ? 8'd40 : 8'd0;
            P_IMPULSE: v = (r >= 1 && r <= 3 && c >= 2 && c <= 4 && !(r == 2 && c == 3)) ? 8'd200 : 8'd0;
            P_DRAMP:   v = 8'd160;
            default:   v = 8'd0;
        endcase
`ifdef SOBEL_THRESH_EN
        v = (v >= 8'd128) ? 8'd255 : 8'd0;
`endif
        return v;
    endfunction

    task automatic run_frame(input int pat, input int gap_pct, output int in_first, output int in_last);
        in_first = 0;
        in_last = 0;
        @(negedge clk);
        gray_vsync = 1'b1;
        gray_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                gray_valid = 1'b0;
                gray_hsync = 1'b0;
                @(negedge clk);
            end
            gray = pix_of(pat, i / W, i % W);
            gray_valid = 1'b1;
            gray_hsync = 1'b1;
            if (i == 0) in_first = cyc + 1;
            if (i == N - 1) in_last = cyc + 1;
        end
        @(negedge clk);
        gray_valid = 1'b0;
        gray_hsync = 1'b0;
        gray_vsync = 1'b0;
        gray = 8'd0;
    endtask

    task automatic wait_out(input int target);
        for (int k = 0; k < 300 && n_tot < target; k++) @(negedge clk);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_p = 1'b1;
        gray = 8'd0; gray_valid = 1'b0; gray_hsync = 1'b0; gray_vsync = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (edge_data !== 8'd0) begin n_fail++; $display("FAIL reset edge_data: got %h want 00", edge_data); end
        n_checks++;
        if (edge_valid !== 1'b0) begin n_fail++; $display("FAIL reset edge_valid: got %b want 0", edge_valid); end
        n_checks++;
        if (edge_hsync !== 1'b0) begin n_fail++; $display("FAIL reset edge_hsync: got %b want 0", edge_hsync); end
        n_checks++;
        if (edge_vsync !== 1'b0) begin n_fail++; $display("FAIL reset edge_vsync: got %b want 0", edge_vsync); end
        rst_p = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_constant();
        int base, vs0, fi, la;
        base = n_tot;
        vs0 = vs_tot;
        run_frame(P_CONST, 0, fi, la);
        wait_out(base + N);
        n_checks++;
        if (n_tot - base !== N) begin n_fail++; $display("FAIL const count: got %0d want %0d", n_tot - base, N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_CONST, i / W, i % W)) begin
                n_fail++; $display("FAIL const px%0d: got %h want %h", i, got[base + i], exp_of(P_CONST, i / W, i % W));
            end
        end
        n_checks++;
        if (vs_tot - vs0 !== N) begin n_fail++; $display("FAIL const vsync span: got %0d want %0d", vs_tot - vs0, N); end
        n_checks++;
        if (out_cyc[base] - fi !== W + 4) begin n_fail++; $display("FAIL first latency: got %0d want %0d", out_cyc[base] - fi, W + 4); end
        n_checks++;
        if (out_cyc[base + N - 1] - la !== W + 4) begin
            n_fail++; $display("FAIL last latency: got %0d want %0d", out_cyc[base + N - 1] - la, W + 4);
        end
        n_checks++;
        if (hs_bad !== 0) begin n_fail++; $display("FAIL hsync follows valid: got %0d bad cycles want 0", hs_bad); end
    endtask

    task automatic test_vstep();
        int base, fi, la;
        base = n_tot;
        run_frame(P_VSTEP, 0, fi, la);
        wait_out(base + N);
        n_checks++;
        if (n_tot - base !== N) begin n_fail++; $display("FAIL vstep count: got %0d want %0d", n_tot - base, N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_VSTEP, i / W, i % W)) begin
                n_fail++; $display("FAIL vstep px%0d: got %h want %h", i, got[base + i], exp_of(P_VSTEP, i / W, i % W));
            end
        end
    endtask

    task automatic test_ramp();
        int base, fi, la;
        base = n_tot;
        run_frame(P_RAMP, 0, fi, la);
        wait_out(base + N);
        n_checks++;
        if (n_tot - base !== N) begin n_fail++; $display("FAIL ramp count: got %0d want %0d", n_tot - base, N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_RAMP, i / W, i % W)) begin
                n_fail++; $display("FAIL ramp px%0d: got %h want %h", i, got[base + i], exp_of(P_RAMP, i / W, i % W));
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, fi, la;
        base = n_tot;
        run_frame(P_HSTEP, 0, fi, la);
        repeat (W + 1) @(negedge clk);
        run_frame(P_IMPULSE, 0, fi, la);
        wait_out(base + 2 * N);
        n_checks++;
        if (n_tot - base !== 2 * N) begin n_fail++; $display("FAIL b2b count: got %0d want %0d", n_tot - base, 2 * N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_HSTEP, i / W, i % W)) begin
                n_fail++; $display("FAIL b2b hstep px%0d: got %h want %h", i, got[base + i], exp_of(P_HSTEP, i / W, i % W));
            end
            n_checks++;
            if (got[base + N + i] !== exp_of(P_IMPULSE, i / W, i % W)) begin
                n_fail++; $display("FAIL b2b impulse px%0d: got %h want %h", i, got[base + N + i], exp_of(P_IMPULSE, i / W, i % W));
            end
        end
    endtask

    task automatic test_gaps();
        int base, fi, la;
        base = n_tot;
        run_frame(P_DRAMP, 30, fi, la);
        wait_out(base + N);
        n_checks++;
        if (n_tot - base !== N) begin n_fail++; $display("FAIL gaps count: got %0d want %0d", n_tot - base, N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_DRAMP, i / W, i % W)) begin
                n_fail++; $display("FAIL gaps px%0d: got %h want %h", i, got[base + i], exp_of(P_DRAMP, i / W, i % W));
            end
        end
    endtask

    task automatic test_abort();
        int base, snap, fi, la;
        @(negedge clk);
        gray_vsync = 1'b1;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            gray = pix_of(P_IMPULSE, i / W, i % W);
            gray_valid = 1'b1;
            gray_hsync = 1'b1;
        end
        @(negedge clk);
        gray_vsync = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        snap = n_tot;
        repeat (10) @(negedge clk);
        gray_valid = 1'b0;
        gray_hsync = 1'b0;
        n_checks++;
        if (n_tot !== snap) begin n_fail++; $display("FAIL abort stray outputs: got %0d want 0", n_tot - snap); end
        n_checks++;
        if (edge_vsync !== 1'b0) begin n_fail++; $display("FAIL abort edge_vsync: got %b want 0", edge_vsync); end
        n_checks++;
        if (edge_valid !== 1'b0) begin n_fail++; $display("FAIL abort edge_valid: got %b want 0", edge_valid); end
        base = n_tot;
        run_frame(P_VSTEP, 0, fi, la);
        wait_out(base + N);
        n_checks++;
        if (n_tot - base !== N) begin n_fail++; $display("FAIL post-abort count: got %0d want %0d", n_tot - base, N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_VSTEP, i / W, i % W)) begin
                n_fail++; $display("FAIL post-abort px%0d: got %h want %h", i, got[base + i], exp_of(P_VSTEP, i / W, i % W));
            end
        end
    endtask

    task automatic test_midreset();
        int base, fi, la;
        @(negedge clk);
        gray_vsync = 1'b1;
        for (int i = 0; i < W + 5; i++) begin
            @(negedge clk);
            gray = pix_of(P_VSTEP, i / W, i % W);
            gray_valid = 1'b1;
        end
        @(negedge clk);
        rst_p = 1'b1;
        gray_valid = 1'b0;
        gray_vsync = 1'b0;
        @(negedge clk);
        n_checks++;
        if (edge_valid !== 1'b0) begin n_fail++; $display("FAIL midreset edge_valid: got %b want 0", edge_valid); end
        n_checks++;
        if (edge_vsync !== 1'b0) begin n_fail++; $display("FAIL midreset edge_vsync: got %b want 0", edge_vsync); end
        rst_p = 1'b0;
        repeat (2) @(negedge clk);
        base = n_tot;
        run_frame(P_DRAMP, 0, fi, la);
        wait_out(base + N);
        n_checks++;
        if (n_tot - base !== N) begin n_fail++; $display("FAIL midreset count: got %0d want %0d", n_tot - base, N); end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (got[base + i] !== exp_of(P_DRAMP, i / W, i % W)) begin
                n_fail++; $display("FAIL midreset px%0d: got %h want %h", i, got[base + i], exp_of(P_DRAMP, i / W, i % W));
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_vstep();
        test_ramp();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
